// File: rtl/fifo_stream_adapter.sv
// Drain stage behind the synchronous FIFO: turns read_en/data_out (one-cycle read latency)
// into a valid/ready stream, with a 2-entry skid buffer, flush, enable gating and a beat counter.
module fifo_stream_adapter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             enable,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t           state, state_next;
  logic [1:0]       occ, occ_next, occ_after_pop;
  logic             inflight;
  logic             pop, capture;
  logic [2:0]       pending;
  logic [WIDTH-1:0] head, tail;

  assign m_valid = (occ != 2'd0);
  assign m_data  = head;
  assign busy    = (state != IDLE);

  always_comb begin
    pop           = m_valid & m_ready;
    capture       = inflight & (state != FLUSH);
    occ_after_pop = occ - {1'b0, pop};
    // Words already owned (buffered + in flight) once this cycle's pop retires.
    pending       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    fifo_rd_en    = rst & enable & ~fifo_empty & ~flush & (state != FLUSH) & (pending < 3'd2);
    occ_next      = flush ? 2'd0 : (occ_after_pop + {1'b0, capture});

    state_next = state;
    if (flush) begin
      state_next = FLUSH;
    end else begin
      case (state)
        IDLE:    if (fifo_rd_en) state_next = RUN;
        RUN:     if ((occ == 2'd0) && !inflight && !fifo_rd_en) state_next = IDLE;
        FLUSH:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      occ      <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      word_cnt <= '0;
    end else begin
      state    <= state_next;
      occ      <= occ_next;
      inflight <= fifo_rd_en;
      if (pop) word_cnt <= word_cnt + CNT_W'(1);
      if (pop && (occ == 2'd2)) head <= tail;
      // A returning word lands at the head only if the buffer is empty after this pop.
      if (capture && !flush) begin
        if (occ_after_pop == 2'd0) head <= fifo_data;
        else                       tail <= fifo_data;
      end
    end
  end

endmodule
